// File: rtl/example3.sv
// example3 -- serial-in / parallel-out shift register with word framing.
//
// Samples one serial bit per rising clk edge and presents the most recent
// WIDTH+1 bits as a parallel word. A shift counter frames groups of WIDTH+1
// bits, and word_valid pulses for one cycle each time a full group has
// been shifted in since reset.
//
// Parameters
//   WIDTH       index of the MSB of the parallel word (word is WIDTH+1 bits)
//   SHIFT_LEFT  1: new bit enters at bit 0 and the word moves toward the MSB
//               0: new bit enters at bit WIDTH and the word moves toward bit 0
//
// Ports
//   clk              rising-edge clock for all state
//   reset            synchronous, active-high clear
//   input_data       serial data bit
//   parallel_output  registered shift-register contents
//   word_valid       registered one-cycle pulse after each complete word
module example3 #(
  parameter int WIDTH      = 7,
  parameter int SHIFT_LEFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_data,
  output logic [WIDTH:0]   parallel_output,
  output logic             word_valid
);

  // A 1-bit word still needs a 1-bit counter even though it never leaves 0.
  localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0]  shift_cnt;
  logic [WIDTH:0] shift_next;

  // WIDTH=0 has no neighbouring bits to keep, so the register simply loads
  // the new sample; the slice forms below would be out of range there.
  generate
    if (WIDTH == 0) begin : g_single
      assign shift_next = input_data;
    end else if (SHIFT_LEFT != 0) begin : g_left
      assign shift_next = {parallel_output[WIDTH-1:0], input_data};
    end else begin : g_right
      assign shift_next = {input_data, parallel_output[WIDTH:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      parallel_output <= '0;
      shift_cnt       <= '0;
      word_valid      <= 1'b0;
    end else begin
      parallel_output <= shift_next;
      // The shift that takes the counter from CNT_MAX back to 0 completes a
      // word, so word_valid is high in exactly the following cycle.
      word_valid <= (shift_cnt == CNT_MAX);
      if (shift_cnt == CNT_MAX) begin
        shift_cnt <= '0;
      end else begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_example3.sv
// Testbench for example3: three instances (default 8-bit left shifter,
// 4-bit right shifter, 1-bit register) driven by the same serial stream and
// compared against a history-of-samples model after every clock edge.
module tb_example3;

  logic       clk;
  logic       reset;
  logic       input_data;
  logic [7:0] po_a;
  logic       wv_a;
  logic [3:0] po_b;
  logic       wv_b;
  logic [0:0] po_c;
  logic       wv_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: every bit sampled since the last reset edge (most recent
  // last) plus the number of shifts since that reset.
  bit hist[$];
  int n_shift = 0;

  example3 #(.WIDTH(7), .SHIFT_LEFT(1)) u_a (
    .clk(clk), .reset(reset), .input_data(input_data),
    .parallel_output(po_a), .word_valid(wv_a));

  example3 #(.WIDTH(3), .SHIFT_LEFT(0)) u_b (
    .clk(clk), .reset(reset), .input_data(input_data),
    .parallel_output(po_b), .word_valid(wv_b));

  example3 #(.WIDTH(0), .SHIFT_LEFT(1)) u_c (
    .clk(clk), .reset(reset), .input_data(input_data),
    .parallel_output(po_c), .word_valid(wv_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected word: the newest sample sits at the entry end, older samples
  // further along, positions beyond the history are zero.
  function automatic logic [31:0] exp_word(input int w, input bit left);
    logic [31:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int i = 0; i <= w; i++) begin
      if (i < n) begin
        if (left) r[i] = hist[n-1-i];
        else      r[w-i] = hist[n-1-i];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_valid(input int w);
    return {31'b0, (n_shift > 0) && (n_shift % (w + 1) == 0)};
  endfunction

  // One clock: a garbage value is put on input_data early in the cycle and
  // replaced by the real value at the falling edge, so only the value
  // present at the rising edge may matter.
  task automatic tick(input bit r, input bit d);
    input_data = 1'($urandom);
    reset      = 1'($urandom);
    @(negedge clk);
    reset      = r;
    input_data = d;
    @(posedge clk);
    if (r) begin
      hist.delete();
      n_shift = 0;
    end else begin
      hist.push_back(d);
      if (hist.size() > 16) void'(hist.pop_front());
      n_shift++;
    end
    #1;
    check("po_w7",  {24'b0, po_a}, exp_word(7, 1'b1));
    check("wv_w7",  {31'b0, wv_a}, exp_valid(7));
    check("po_w3r", {28'b0, po_b}, exp_word(3, 1'b0));
    check("wv_w3r", {31'b0, wv_b}, exp_valid(3));
    check("po_w0",  {31'b0, po_c}, exp_word(0, 1'b1));
    check("wv_w0",  {31'b0, wv_c}, exp_valid(0));
  endtask

  initial begin
    reset      = 1'b1;
    input_data = 1'b1;

    // Reset state.
    tick(1'b1, 1'b1);
    check("rst_po", {24'b0, po_a}, 32'h00);
    check("rst_wv", {31'b0, wv_a}, 32'h0);

    // 1,0,1,1 -> 0000_1011, no word yet.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("seq1011_po", {24'b0, po_a}, 32'h0B);
    check("seq1011_wv", {31'b0, wv_a}, 32'h0);

    // Eight 1s after reset: valid only after the 8th, then 0 -> FE.
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      check("ones_wv", {31'b0, wv_a}, {31'b0, (i == 7)});
    end
    check("ones_po", {24'b0, po_a}, 32'hFF);
    tick(1'b0, 1'b0);
    check("ones9_po", {24'b0, po_a}, 32'hFE);
    check("ones9_wv", {31'b0, wv_a}, 32'h0);

    // Partial word discarded by reset; count restarts.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      check("midrst_po", {24'b0, po_a}, 32'h00);
      check("midrst_wv", {31'b0, wv_a}, {31'b0, (i == 7)});
    end

    // WIDTH=3 right shifter: 1,0,0,0 -> 0001 with valid after the 4th.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("w3_pre_wv", {31'b0, wv_b}, 32'h0);
    tick(1'b0, 1'b0);
    check("w3_po", {28'b0, po_b}, 32'h1);
    check("w3_wv", {31'b0, wv_b}, 32'h1);

    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 19) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
